rx_bit_timer: RTL
=================

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clocks per serial bit period; legal range 2..16.
REQ-002 Parameter SAMPLE_POINT, default 3: phase value at which a bit is sampled; legal range 1..CLKS_PER_BIT-1.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset; synchronous, active-low.
REQ-005 clear  input  1  synchronous clear of all timing state; active-high.
REQ-006 rcving  input  1  receive-in-progress enable; timer runs only while high.
REQ-007 d_edge  input  1  one-cycle pulse marking a line transition; used to resynchronise bit phase.
REQ-008 shift_enable  output  1  one-cycle pulse at each bit sample point.
REQ-009 byte_received  output  1  one-cycle pulse marking the 8th sampled bit of a byte.
REQ-010 bit_count  output  3  number of bits sampled so far in the current byte, 0..7.

Function
REQ-011 The block SHALL hold a 4-bit registered phase counter and a 3-bit registered bit counter; bit_count SHALL equal the bit counter.
REQ-012 Phase update priority, highest first: n_rst=0 -> 0; clear=1 -> 0; rcving=0 -> 0; d_edge=1 -> 0; phase==CLKS_PER_BIT-1 -> 0; else phase+1.
REQ-013 shift_enable SHALL be a decode of current state: 1 iff rcving=1 and phase==SAMPLE_POINT, with no further qualification.
REQ-014 shift_enable SHALL still assert in a cycle where d_edge=1 coincides with phase==SAMPLE_POINT; the resync affects only the next phase value.
REQ-015 The bit counter SHALL increment on each cycle with shift_enable=1 and wrap 7 -> 0.
REQ-016 byte_received SHALL be 1 iff shift_enable=1 and bit counter==7, concurrent with that shift_enable.
REQ-017 The bit counter SHALL be forced to 0 by n_rst=0, clear=1 or rcving=0, with the same priority as in REQ-012.
REQ-018 clear SHALL take priority over d_edge and shift_enable-driven increments in the same cycle.
REQ-019 d_edge while rcving=0 SHALL have no effect.
REQ-020 With rcving held high and no d_edge, shift_enable SHALL recur every CLKS_PER_BIT cycles exactly.
REQ-021 Phase SHALL never exceed CLKS_PER_BIT-1; an edge-driven restart SHALL never skip or duplicate a bit count.

Reset
REQ-022 After a rising edge with n_rst=0: phase=0, bit_count=0, shift_enable=0, byte_received=0, regardless of all other inputs.
REQ-023 Outputs SHALL remain 0 for every cycle in which n_rst was 0 at the preceding edge; since SAMPLE_POINT>=1, no output gating beyond REQ-013 is needed.
REQ-024 An n_rst=0 assertion mid-byte SHALL abandon the partial byte; counting restarts from bit 0 on release.

Verification
REQ-025 Reset: n_rst=0 for 2 edges with rcving=1 and d_edge=1 -> bit_count=0, shift_enable=0, byte_received=0.
REQ-026 Free run: defaults, rcving=1 from cycle 0, no d_edge -> shift_enable at cycles 3,11,19,...,59; byte_received only at cycle 59; bit_count=0 at cycle 60.
REQ-027 Resync: d_edge at cycle 6 -> phase=0 at cycle 7; next shift_enable at cycle 10, not 11; later pulses every 8 cycles.
REQ-028 Mid-byte clear: clear for 1 cycle after 3 pulses -> bit_count=0; byte_received on the 8th subsequent shift_enable, not the 5th.
REQ-029 Enable drop: rcving=0 for 4 cycles after 5 pulses -> no pulses, bit_count=0; rcving=1 again -> first shift_enable 3 cycles later, bit_count counts 1 after it.
REQ-030 Collision: d_edge and clear together at phase 3 -> no shift_enable counted, bit_count=0, phase=0 next cycle.

Source files
------------

// File: rtl/rx_bit_timer_if.sv
// Handshake bundle for the receive bit timer.
// Master drives line/control status, slave returns bit timing.
interface rx_bit_timer_if;
  logic       clear;
  logic       rcving;
  logic       d_edge;
  logic       shift_enable;
  logic       byte_received;
  logic [2:0] bit_count;

  modport master (
    output clear,
    output rcving,
    output d_edge,
    input  shift_enable,
    input  byte_received,
    input  bit_count
  );

  modport slave (
    input  clear,
    input  rcving,
    input  d_edge,
    output shift_enable,
    output byte_received,
    output bit_count
  );
endinterface

// File: rtl/rx_bit_timer.sv
// Serial receive bit timer: phase counter with edge resync,
// sample-point strobe and per-byte bit counter.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input logic          clk,
  input logic          n_rst,
  rx_bit_timer_if.slave bus
);
  localparam logic [3:0] LAST = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] SP   = 4'(SAMPLE_POINT);

  logic [3:0] phase_q;
  logic [2:0] cnt_q;
  logic       se;

  // Strobe is a pure decode of state so a coincident resync
  // edge cannot suppress the sample it lands on.
  assign se = bus.rcving && (phase_q == SP);

  assign bus.shift_enable  = se;
  assign bus.byte_received = se && (cnt_q == 3'd7);
  assign bus.bit_count     = cnt_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else if (bus.clear || !bus.rcving) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.d_edge || phase_q == LAST)
        phase_q <= '0;
      else
        phase_q <= phase_q + 4'd1;
      if (se)
        cnt_q <= cnt_q + 3'd1;
    end
  end
endmodule
